// File: rtl/spmp_pkg.sv
// Shared SPMP types: cfg byte layout, address-match modes, access kinds and checker FSM states.
package spmp_pkg;

    localparam int unsigned CfgW    = 8;
    localparam int unsigned CfgRBit = 0;
    localparam int unsigned CfgWBit = 1;
    localparam int unsigned CfgXBit = 2;
    localparam int unsigned CfgSBit = 7;

    typedef enum logic [1:0] {
        SPMP_OFF   = 2'd0,
        SPMP_TOR   = 2'd1,
        SPMP_NA4   = 2'd2,
        SPMP_NAPOT = 2'd3
    } spmp_mode_e;

    typedef enum logic [1:0] {
        SPMP_ACC_READ  = 2'd0,
        SPMP_ACC_WRITE = 2'd1,
        SPMP_ACC_EXEC  = 2'd2
    } spmp_acc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } spmp_state_e;

    typedef struct packed {
        logic       s;
        logic [1:0] reserved;
        spmp_mode_e a;
        logic       x;
        logic       w;
        logic       r;
    } spmp_cfg_t;

    // Grant for a matched entry: privilege must equal the S bit and the access kind must be enabled.
    function automatic logic spmp_allow(input spmp_cfg_t cfg, input logic [1:0] acc,
                                        input logic priv_s);
        logic [CfgW-1:0] raw;
        logic            perm;
        raw = cfg;
        case (acc)
            SPMP_ACC_READ:  perm = raw[CfgRBit];
            SPMP_ACC_WRITE: perm = raw[CfgWBit];
            SPMP_ACC_EXEC:  perm = raw[CfgXBit];
            default:        perm = 1'b0;
        endcase
        return perm && (raw[CfgSBit] == priv_s);
    endfunction

endpackage

// File: rtl/spmp_entry_match.sv
// Combinational address matcher for one SPMP entry (OFF / TOR / NA4 / NAPOT).
module spmp_entry_match
    import spmp_pkg::*;
#(
    parameter int unsigned AW = 54
) (
    input  logic [AW-1:0] a_i,
    input  spmp_cfg_t     cfg_i,
    input  logic [AW-1:0] addr_cur_i,
    input  logic [AW-1:0] addr_prev_i,
    output logic          match_o
);

    logic [AW-1:0] napot_care;
    logic          unused_cfg;

    // Bits 0..t (trailing ones plus the first zero) are don't-care; all-ones wraps to care == 0.
    assign napot_care = ~(addr_cur_i ^ (addr_cur_i + AW'(1)));
    assign unused_cfg = ^{cfg_i.s, cfg_i.reserved, cfg_i.x, cfg_i.w, cfg_i.r};

    always_comb begin
        match_o = 1'b0;
        case (cfg_i.a)
            SPMP_TOR:   match_o = (addr_prev_i < addr_cur_i) && (a_i >= addr_prev_i)
                                  && (a_i < addr_cur_i);
            SPMP_NA4:   match_o = (a_i == addr_cur_i);
            SPMP_NAPOT: match_o = ((a_i ^ addr_cur_i) & napot_care) == '0;
            default:    match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/spmp_seq_checker.sv
// Iterative SPMP permission checker: scans EntriesPerCycle entries per cycle and reports the
// lowest-indexed matching entry together with the allow/deny decision.
module spmp_seq_checker
    import spmp_pkg::*;
#(
    parameter int unsigned NrEntries       = 64,
    parameter int unsigned EntriesPerCycle = 8,
    parameter int unsigned PLEN            = 56
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [PLEN-1:0]                req_addr_i,
    input  logic [1:0]                     req_acc_i,
    input  logic                           req_priv_s_i,
    input  logic [NrEntries*8-1:0]         spmp_cfg_i,
    input  logic [NrEntries*(PLEN-2)-1:0]  spmp_addr_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic                           resp_allow_o,
    output logic                           resp_match_o,
    output logic [$clog2(NrEntries)-1:0]   resp_idx_o
);

    localparam int unsigned K        = EntriesPerCycle;
    localparam int unsigned AW       = PLEN - 2;
    localparam int unsigned IdxW     = $clog2(NrEntries);
    localparam int unsigned NrChunks = NrEntries / K;
    localparam int unsigned ChunkW   = (NrChunks > 1) ? $clog2(NrChunks) : 1;
    localparam int unsigned LaneW    = (K > 1) ? $clog2(K) : 1;
    localparam logic [ChunkW-1:0] LastChunk = ChunkW'(NrChunks - 1);

    spmp_state_e       state_q, state_d;
    logic [ChunkW-1:0] chunk_q, chunk_d;
    logic [AW-1:0]     a_q, a_d;
    logic [1:0]        acc_q, acc_d;
    logic              priv_q, priv_d;
    logic              allow_q, allow_d;
    logic              match_q, match_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic [AW-1:0]     addr_arr [NrEntries];
    spmp_cfg_t         cfg_arr  [NrEntries];
    logic [IdxW-1:0]   chunk_base;
    logic [K-1:0]      lane_match;
    logic              hit_any;
    logic [LaneW-1:0]  hit_lane;
    logic [IdxW-1:0]   hit_idx;
    spmp_cfg_t         hit_cfg;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr_i[1:0];

    for (genvar i = 0; i < NrEntries; i++) begin : g_unpack
        assign addr_arr[i] = spmp_addr_i[i*AW +: AW];
        assign cfg_arr[i]  = spmp_cfg_t'(spmp_cfg_i[i*CfgW +: CfgW]);
    end

    assign chunk_base = IdxW'(chunk_q) * IdxW'(K);

    // Lane 0 reaches back into the previous chunk for its TOR lower bound.
    for (genvar j = 0; j < K; j++) begin : g_lane
        logic [IdxW-1:0] lane_idx;
        logic [AW-1:0]   lane_prev;
        assign lane_idx  = chunk_base + IdxW'(j);
        assign lane_prev = (lane_idx == '0) ? '0 : addr_arr[lane_idx - IdxW'(1)];

        spmp_entry_match #(
            .AW(AW)
        ) u_match (
            .a_i        (a_q),
            .cfg_i      (cfg_arr[lane_idx]),
            .addr_cur_i (addr_arr[lane_idx]),
            .addr_prev_i(lane_prev),
            .match_o    (lane_match[j])
        );
    end

    // Lowest-index priority encoder over this chunk's lanes.
    always_comb begin
        hit_any  = 1'b0;
        hit_lane = '0;
        for (int j = int'(K) - 1; j >= 0; j--) begin
            if (lane_match[j]) begin
                hit_any  = 1'b1;
                hit_lane = LaneW'(j);
            end
        end
    end

    assign hit_idx = chunk_base + IdxW'(hit_lane);
    assign hit_cfg = cfg_arr[hit_idx];

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        a_d     = a_q;
        acc_d   = acc_q;
        priv_d  = priv_q;
        allow_d = allow_q;
        match_d = match_q;
        idx_d   = idx_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            chunk_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        a_d     = req_addr_i[PLEN-1:2];
                        acc_d   = req_acc_i;
                        priv_d  = req_priv_s_i;
                        chunk_d = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_any) begin
                        match_d = 1'b1;
                        idx_d   = hit_idx;
                        allow_d = spmp_allow(hit_cfg, acc_q, priv_q);
                        state_d = ST_RESP;
                    end else if (chunk_q == LastChunk) begin
                        match_d = 1'b0;
                        idx_d   = '0;
                        allow_d = priv_q;
                        state_d = ST_RESP;
                    end else begin
                        chunk_d = chunk_q + ChunkW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            chunk_q <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            priv_q  <= 1'b0;
            allow_q <= 1'b0;
            match_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            priv_q  <= priv_d;
            allow_q <= allow_d;
            match_q <= match_d;
            idx_q   <= idx_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_allow_o = allow_q;
    assign resp_match_o = match_q;
    assign resp_idx_o   = idx_q;

endmodule

// File: tb/tb_spmp_seq_checker.sv
// Self-checking bench for spmp_seq_checker: directed scenarios plus randomized entry tables,
// compared against an entry-by-entry reference model of the SPMP matching rules.
module tb_spmp_seq_checker;

    localparam int unsigned NE = 64;
    localparam int unsigned K  = 8;
    localparam int unsigned PL = 56;
    localparam int unsigned AW = PL - 2;
    localparam int unsigned IW = 6;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               flush_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [PL-1:0]      req_addr_i;
    logic [1:0]         req_acc_i;
    logic               req_priv_s_i;
    logic [NE*8-1:0]    spmp_cfg_i;
    logic [NE*AW-1:0]   spmp_addr_i;
    logic               resp_valid_o;
    logic               resp_ready_i;
    logic               resp_allow_o;
    logic               resp_match_o;
    logic [IW-1:0]      resp_idx_o;

    logic [7:0]    cfg_m  [NE];
    logic [AW-1:0] addr_m [NE];
    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    spmp_seq_checker #(.NrEntries(NE), .EntriesPerCycle(K), .PLEN(PL)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_acc_i   (req_acc_i),
        .req_priv_s_i(req_priv_s_i),
        .spmp_cfg_i  (spmp_cfg_i),
        .spmp_addr_i (spmp_addr_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_allow_o(resp_allow_o),
        .resp_match_o(resp_match_o),
        .resp_idx_o  (resp_idx_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_entries();
        for (int i = 0; i < NE; i++) begin
            cfg_m[i]  = 8'h00;
            addr_m[i] = '0;
        end
    endtask

    task automatic load_entries();
        for (int i = 0; i < NE; i++) begin
            spmp_cfg_i[i*8 +: 8]   = cfg_m[i];
            spmp_addr_i[i*AW +: AW] = addr_m[i];
        end
    endtask

    // Walk the table from entry 0 upwards; the first matching entry decides.
    function automatic void model(input logic [AW-1:0] a, input int acc, input bit priv,
                                  output bit m, output int idx, output bit allow, output int lat);
        logic [AW-1:0] cur, lo;
        bit hit;
        int t;
        m = 1'b0; idx = 0; allow = priv; lat = NE / K + 1;
        for (int i = 0; i < NE; i++) begin
            cur = addr_m[i];
            lo  = (i == 0) ? '0 : addr_m[i-1];
            hit = 1'b0;
            case (cfg_m[i][4:3])
                2'd1: hit = (lo <= a) && (a < cur);
                2'd2: hit = (a == cur);
                2'd3: begin
                    t = 0;
                    while (t < int'(AW) && cur[t]) t++;
                    if (t + 1 >= int'(AW)) hit = 1'b1;
                    else hit = ((a >> (t + 1)) == (cur >> (t + 1)));
                end
                default: hit = 1'b0;
            endcase
            if (hit) begin
                m = 1'b1; idx = i; lat = i / int'(K) + 2;
                allow = (cfg_m[i][7] == priv) && (acc < 3) && cfg_m[i][acc];
                break;
            end
        end
    endfunction

    // Issue one request from IDLE, check the response, optionally stall it, then hand it off.
    task automatic do_req(input logic [PL-1:0] addr, input int acc, input bit priv,
                          input int hold, input string tag);
        bit em, ea;
        int ei, el, lat;
        model(addr[PL-1:2], acc, priv, em, ei, ea, el);
        chk({tag, " ready"}, 64'(req_ready_o), 64'(1));
        req_valid_i = 1'b1; req_addr_i = addr; req_acc_i = 2'(acc); req_priv_s_i = priv;
        resp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (resp_valid_o !== 1'b1 && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (resp_valid_o !== 1'b1) begin
            chk({tag, " timeout"}, 64'(resp_valid_o), 64'(1));
            flush_i = 1'b1; @(posedge clk_i); #1; flush_i = 1'b0;
            return;
        end
        chk({tag, " lat"},   64'(lat),          64'(el));
        chk({tag, " match"}, 64'(resp_match_o), 64'(em));
        chk({tag, " idx"},   64'(resp_idx_o),   64'(ei));
        chk({tag, " allow"}, 64'(resp_allow_o), 64'(ea));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk_i); #1;
            chk({tag, " hold vld/rdy"}, 64'({resp_valid_o, req_ready_o}), 64'(2'b10));
            chk({tag, " hold data"}, 64'({resp_match_o, resp_idx_o, resp_allow_o}),
                64'({em, IW'(ei), ea}));
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        chk({tag, " post hs vld/rdy"}, 64'({resp_valid_o, req_ready_o}), 64'(2'b01));
    endtask

    // Start a full-length scan and kill it during the third SCAN cycle.
    task automatic scan_abort(input bit use_rst, input string tag);
        int seen;
        clear_entries(); load_entries();
        req_valid_i = 1'b1; req_addr_i = PL'(56'h1_0000); req_acc_i = 2'd2; req_priv_s_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; flush_i = 1'b0;
        chk({tag, " vld/rdy"}, 64'({resp_valid_o, req_ready_o}), 64'(2'b01));
        if (use_rst)
            chk({tag, " resp cleared"}, 64'({resp_match_o, resp_idx_o, resp_allow_o}), 64'(0));
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            if (resp_valid_o !== 1'b0) seen++;
        end
        chk({tag, " no late resp"}, 64'(seen), 64'(0));
    endtask

    initial begin
        logic [AW-1:0] base, mask;
        int t;
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_acc_i = '0;
        req_priv_s_i = 1'b0; resp_ready_i = 1'b0;
        clear_entries(); load_entries();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("reset ready", 64'(req_ready_o), 64'(1));
        chk("reset resp", 64'({resp_valid_o, resp_allow_o, resp_match_o, resp_idx_o}), 64'(0));

        // NAPOT region on entry 0, S-mode R|X
        cfg_m[0] = 8'h9D; addr_m[0] = AW'(54'h2FFF_FFFF); load_entries();
        do_req(PL'(56'h8000_1000), 0, 1'b1, 5, "napot S rd");
        do_req(PL'(56'h8000_1000), 0, 1'b0, 0, "napot U rd");

        clear_entries(); load_entries();
        do_req(PL'(56'h1_0000), 2, 1'b0, 0, "off U ex");
        do_req(PL'(56'h1_0000), 2, 1'b1, 0, "off S ex");

        // TOR on entry 41 with its lower bound in entry 40
        addr_m[40] = AW'(54'h4000); addr_m[41] = AW'(54'h4400); cfg_m[41] = 8'h0A; load_entries();
        do_req(PL'(56'h1_0FFC), 1, 1'b0, 0, "tor U wr in");
        do_req(PL'(56'h1_1000), 1, 1'b0, 0, "tor U wr out");
        do_req(PL'(56'h1_0000), 1, 1'b0, 0, "tor U wr lo");

        scan_abort(1'b0, "flush");
        do_req(PL'(56'h1_0FFC), 1, 1'b0, 0, "after flush");
        scan_abort(1'b1, "rst");
        addr_m[40] = AW'(54'h4000); addr_m[41] = AW'(54'h4400); cfg_m[41] = 8'h0A; load_entries();
        do_req(PL'(56'h1_0FFC), 1, 1'b0, 0, "after rst");

        // Two NA4 entries on the same granule: the lower index wins inside chunk 0
        clear_entries();
        addr_m[3] = AW'(54'h800); cfg_m[3] = 8'h11;
        addr_m[12] = AW'(54'h800); cfg_m[12] = 8'h17; load_entries();
        do_req(PL'(56'h2000), 0, 1'b0, 0, "na4 prio");
        do_req(PL'(56'h2000), 1, 1'b0, 0, "na4 wr");
        do_req(PL'(56'h2000), 3, 1'b0, 0, "na4 acc3");

        // Randomized tables and back-to-back requests
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NE; i++) begin
                cfg_m[i] = 8'($urandom);
                cfg_m[i][6:5] = 2'($urandom);
                if ($urandom_range(0, 1) == 0) cfg_m[i][4:3] = 2'd0;
                addr_m[i] = AW'($urandom_range(0, 1023));
                if (cfg_m[i][4:3] == 2'd3) begin
                    t = int'($urandom_range(0, 6));
                    base = AW'($urandom_range(0, 1023));
                    mask = (AW'(1) << (t + 1)) - AW'(1);
                    addr_m[i] = (base & ~mask) | ((AW'(1) << t) - AW'(1));
                end
            end
            load_entries();
            for (int r = 0; r < 6; r++) begin
                do_req({PL'($urandom_range(0, 1100)), 2'($urandom)} , int'($urandom_range(0, 3)),
                       1'($urandom), int'($urandom_range(0, 2)), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
